// File: rtl/access_ctrl_multi.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module      : access_ctrl_multi
// Description : Multi-user password access controller. Accepts a session
//               command (user, change flag), reads the stored password from
//               an external synchronous RAM with MEM_LAT cycles of latency,
//               compares it with the entered password, and grants access,
//               accepts a new password, or counts failures up to a lockout.
//               Optional macro ACCESS_CTRL_LOCKOUT_TIMER_EN makes the lockout
//               timed (LOCK_CYCLES); without it the lockout lasts until rst.
// Revision    : 1.0 - initial parametrised multi-user release
//============================================================================
module access_ctrl_multi #(
  parameter int PW_W        = 16,
  parameter int USER_W      = 4,
  parameter int MAX_FAILS   = 3,
  parameter int MEM_LAT     = 1,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [USER_W-1:0] cmd_user,
  input  logic              cmd_change,
  input  logic              pw_valid,
  input  logic [PW_W-1:0]   pw_data,
  input  logic              logout,
  output logic [USER_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [PW_W-1:0]   mem_rd_data,
  output logic              mem_wr_en,
  output logic [PW_W-1:0]   mem_wr_data,
  output logic              access_grant,
  output logic              locked,
  output logic [3:0]        fail_count
);

  localparam int               c_LAT_W     = $clog2(MEM_LAT + 1);
  localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(MEM_LAT);
  localparam logic [3:0]       c_MAX_FAILS = 4'(MAX_FAILS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_PW = 3'd1,
    S_READ    = 3'd2,
    S_CHECK   = 3'd3,
    S_GRANTED = 3'd4,
    S_NEW_PW  = 3'd5,
    S_LOCKED  = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [USER_W-1:0]   r_user;
  logic                r_change;
  logic [PW_W-1:0]     r_pw;
  logic [PW_W-1:0]     r_rd_word;
  logic [PW_W-1:0]     r_wr_data;
  logic                r_rd_en;
  logic                r_wr_en;
  logic [c_LAT_W-1:0]  r_lat_cnt;
  logic [3:0]          r_fail;
  logic                w_match;
  logic [3:0]          w_fail_inc;
  logic                w_fail_hit;
  logic                w_lock_done;

  assign w_match    = (r_pw == r_rd_word);
  // Saturating increment so the count can never pass MAX_FAILS.
  assign w_fail_inc = (r_fail >= c_MAX_FAILS) ? c_MAX_FAILS : r_fail + 4'd1;
  assign w_fail_hit = (w_fail_inc == c_MAX_FAILS);

`ifdef ACCESS_CTRL_LOCKOUT_TIMER_EN
  localparam int c_LOCK_W = $clog2(LOCK_CYCLES + 1);
  logic [c_LOCK_W-1:0] r_lock_cnt;

  // Lockout timer: loaded on entry so LOCKED lasts exactly LOCK_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_cnt <= '0;
    end else if (r_state == S_CHECK && !w_match && w_fail_hit) begin
      r_lock_cnt <= c_LOCK_W'(LOCK_CYCLES - 1);
    end else if (r_state == S_LOCKED && r_lock_cnt != '0) begin
      r_lock_cnt <= r_lock_cnt - 1'b1;
    end
  end

  assign w_lock_done = (r_lock_cnt == '0);
`else
  // Without the timer the lockout only ends on rst.
  assign w_lock_done = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    access_grant = 1'b0;
    locked       = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_next = S_WAIT_PW;
      end
      S_WAIT_PW: if (pw_valid) w_state_next = S_READ;
      S_READ:    if (r_lat_cnt == c_LAT_LAST) w_state_next = S_CHECK;
      S_CHECK: begin
        if (w_match)         w_state_next = r_change ? S_NEW_PW : S_GRANTED;
        else if (w_fail_hit) w_state_next = S_LOCKED;
        else                 w_state_next = S_WAIT_PW;
      end
      S_GRANTED: begin
        access_grant = 1'b1;
        if (logout) w_state_next = S_IDLE;
      end
      S_NEW_PW:  if (pw_valid) w_state_next = S_IDLE;
      S_LOCKED: begin
        locked = 1'b1;
        if (w_lock_done) w_state_next = S_IDLE;
      end
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Session datapath: latches, memory strobes, latency counter, fail count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_user    <= '0;
      r_change  <= 1'b0;
      r_pw      <= '0;
      r_rd_word <= '0;
      r_wr_data <= '0;
      r_rd_en   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_lat_cnt <= '0;
      r_fail    <= 4'd0;
    end else begin
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_user   <= cmd_user;
            r_change <= cmd_change;
            r_fail   <= 4'd0;
          end
        end
        S_WAIT_PW: begin
          if (pw_valid) begin
            r_pw      <= pw_data;
            r_rd_en   <= 1'b1;
            r_lat_cnt <= '0;
          end
        end
        S_READ: begin
          // Counter starts on the strobe cycle; data is sampled MEM_LAT later.
          if (r_lat_cnt == c_LAT_LAST) r_rd_word <= mem_rd_data;
          else                         r_lat_cnt <= r_lat_cnt + 1'b1;
        end
        S_CHECK: begin
          if (w_match && !r_change) r_fail <= 4'd0;
          else if (!w_match)        r_fail <= w_fail_inc;
        end
        S_NEW_PW: begin
          if (pw_valid) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= pw_data;
          end
        end
        S_LOCKED: begin
          if (w_lock_done) r_fail <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr    = r_user;
  assign mem_rd_en   = r_rd_en;
  assign mem_wr_en   = r_wr_en;
  assign mem_wr_data = r_wr_data;
  assign fail_count  = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_access_ctrl_multi.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module      : tb_access_ctrl_multi
// Description : Bench for access_ctrl_multi. Two instances (MEM_LAT 1 and 4)
//               each with their own RAM model; a session-level reference
//               model predicts grant/lock/fail outcomes.
// Revision    : 1.0 - initial release
//============================================================================
module tb_access_ctrl_multi;

  localparam int PW_W = 16, USER_W = 4, MAX_FAILS = 3, LOCK_CYCLES = 8;
  localparam int LAT0 = 1, LAT1 = 4;
  localparam int O_RETRY = 0, O_GRANT = 1, O_NEWPW = 2, O_LOCK = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              cmd_valid [2];
  logic              cmd_ready [2];
  logic [USER_W-1:0] cmd_user [2];
  logic              cmd_change [2];
  logic              pw_valid [2];
  logic [PW_W-1:0]   pw_data [2];
  logic              logout [2];
  logic [USER_W-1:0] mem_addr [2];
  logic              mem_rd_en [2];
  logic [PW_W-1:0]   mem_rd_data [2];
  logic              mem_wr_en [2];
  logic [PW_W-1:0]   mem_wr_data [2];
  logic              access_grant [2];
  logic              locked [2];
  logic [3:0]        fail_count [2];

  access_ctrl_multi #(.PW_W(PW_W), .USER_W(USER_W), .MAX_FAILS(MAX_FAILS),
                      .MEM_LAT(LAT0), .LOCK_CYCLES(LOCK_CYCLES)) u_lat1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_user(cmd_user[0]), .cmd_change(cmd_change[0]), .pw_valid(pw_valid[0]),
    .pw_data(pw_data[0]), .logout(logout[0]), .mem_addr(mem_addr[0]),
    .mem_rd_en(mem_rd_en[0]), .mem_rd_data(mem_rd_data[0]), .mem_wr_en(mem_wr_en[0]),
    .mem_wr_data(mem_wr_data[0]), .access_grant(access_grant[0]), .locked(locked[0]),
    .fail_count(fail_count[0]));

  access_ctrl_multi #(.PW_W(PW_W), .USER_W(USER_W), .MAX_FAILS(MAX_FAILS),
                      .MEM_LAT(LAT1), .LOCK_CYCLES(LOCK_CYCLES)) u_lat4 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_user(cmd_user[1]), .cmd_change(cmd_change[1]), .pw_valid(pw_valid[1]),
    .pw_data(pw_data[1]), .logout(logout[1]), .mem_addr(mem_addr[1]),
    .mem_rd_en(mem_rd_en[1]), .mem_rd_data(mem_rd_data[1]), .mem_wr_en(mem_wr_en[1]),
    .mem_wr_data(mem_wr_data[1]), .access_grant(access_grant[1]), .locked(locked[1]),
    .fail_count(fail_count[1]));

  // RAM models: read data is valid only on the cycle MEM_LAT after the strobe,
  // other cycles carry random garbage.
  logic [PW_W-1:0] ram [2][16];
  logic [PW_W-1:0] pipe [2][4];
  logic            ld_en = 1'b0;
  logic            ld_d = 1'b0;
  logic [3:0]      ld_a = 4'd0;
  logic [PW_W-1:0] ld_v = '0;
  int              wr_pulses [2] = '{0, 0};
  int              overlap = 0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_wr_en[d]) begin
        ram[d][mem_addr[d]] <= mem_wr_data[d];
        wr_pulses[d] <= wr_pulses[d] + 1;
      end
      pipe[d][0] <= mem_rd_en[d] ? ram[d][mem_addr[d]] : PW_W'($urandom);
      for (int k = 1; k < 4; k++) pipe[d][k] <= pipe[d][k-1];
      if (mem_rd_en[d] && mem_wr_en[d]) overlap <= overlap + 1;
    end
    if (ld_en) ram[ld_d][ld_a] <= ld_v;
  end

  assign mem_rd_data[0] = pipe[0][LAT0-1];
  assign mem_rd_data[1] = pipe[1][LAT1-1];

  // Reference model state.
  logic [PW_W-1:0]   model_ram [2][16];
  int                model_fails [2];
  logic [USER_W-1:0] cur_user [2];
  logic              cur_change [2];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0; cmd_user[d] = '0; cmd_change[d] = 1'b0;
      pw_valid[d] = 1'b0; pw_data[d] = '0; logout[d] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick(); tick();
    rst = 1'b0;
    model_fails[0] = 0; model_fails[1] = 0;
  endtask

  task automatic set_ram(input logic d, input logic [3:0] a, input logic [PW_W-1:0] v);
    ld_en = 1'b1; ld_d = d; ld_a = a; ld_v = v;
    tick();
    ld_en = 1'b0;
    model_ram[d][a] = v;
  endtask

  // All outputs packed: ready, grant, locked, rd, wr, fail, addr, wr_data.
  function automatic logic [28:0] outs(input int d);
    return {cmd_ready[d], access_grant[d], locked[d], mem_rd_en[d], mem_wr_en[d],
            fail_count[d], mem_addr[d], mem_wr_data[d]};
  endfunction

  task automatic start(input int d, input logic [USER_W-1:0] u, input logic ch);
    checks++;
    if (cmd_ready[d] !== 1'b1) begin
      errors++; $display("FAIL start_ready d=%0d got %b want 1", d, cmd_ready[d]);
    end
    cmd_valid[d] = 1'b1; cmd_user[d] = u; cmd_change[d] = ch;
    tick();
    cmd_valid[d] = 1'b0; cmd_user[d] = '0; cmd_change[d] = 1'b0;
    cur_user[d] = u; cur_change[d] = ch; model_fails[d] = 0;
    checks++;
    if (cmd_ready[d] !== 1'b0 || fail_count[d] !== 4'd0) begin
      errors++; $display("FAIL start_accept d=%0d ready=%b fail=%0d want 0/0",
                         d, cmd_ready[d], fail_count[d]);
    end
  endtask

  // Enter one password and check the session outcome 2+MEM_LAT cycles later.
  task automatic do_pw(input int d, input logic [PW_W-1:0] pw, output int oc);
    int lat;
    logic [2:0] exp_o;
    lat = (d == 0) ? LAT0 : LAT1;
    pw_valid[d] = 1'b1; pw_data[d] = pw;
    tick();
    pw_valid[d] = 1'b0;
    checks++;
    if (mem_rd_en[d] !== 1'b1 || mem_addr[d] !== cur_user[d]) begin
      errors++; $display("FAIL rd_strobe d=%0d rd=%b addr=%0d want 1/%0d",
                         d, mem_rd_en[d], mem_addr[d], cur_user[d]);
    end
    for (int i = 0; i < lat + 1; i++) begin
      cmd_valid[d] = 1'($urandom_range(0, 1)); cmd_user[d] = USER_W'($urandom);
      pw_valid[d] = 1'($urandom_range(0, 1)); pw_data[d] = PW_W'($urandom);
      tick();
      if (i == 0) begin
        checks++;
        if (mem_rd_en[d] !== 1'b0) begin
          errors++; $display("FAIL rd_one_cycle d=%0d got %b want 0", d, mem_rd_en[d]);
        end
      end
    end
    clear_inputs();
    checks++;
    if (access_grant[d] !== 1'b0 || cmd_ready[d] !== 1'b0 || mem_addr[d] !== cur_user[d]) begin
      errors++; $display("FAIL pre_check d=%0d grant=%b ready=%b addr=%0d want 0/0/%0d",
                         d, access_grant[d], cmd_ready[d], mem_addr[d], cur_user[d]);
    end
    if (pw == model_ram[d][cur_user[d]]) begin
      oc = cur_change[d] ? O_NEWPW : O_GRANT;
      if (!cur_change[d]) model_fails[d] = 0;
    end else begin
      model_fails[d] = model_fails[d] + 1;
      oc = (model_fails[d] == MAX_FAILS) ? O_LOCK : O_RETRY;
    end
    tick();
    exp_o = {oc == O_GRANT, oc == O_LOCK, 1'b0};
    checks++;
    if ({access_grant[d], locked[d], cmd_ready[d]} !== exp_o ||
        fail_count[d] !== 4'(model_fails[d])) begin
      errors++; $display("FAIL outcome d=%0d grant/lock/ready=%b fail=%0d want %b fail=%0d",
                         d, {access_grant[d], locked[d], cmd_ready[d]}, fail_count[d],
                         exp_o, model_fails[d]);
    end
  endtask

  task automatic do_logout(input int d);
    logout[d] = 1'b1; pw_valid[d] = 1'b1; pw_data[d] = PW_W'($urandom);
    tick();
    clear_inputs();
    checks++;
    if (access_grant[d] !== 1'b0 || cmd_ready[d] !== 1'b1) begin
      errors++; $display("FAIL logout d=%0d grant=%b ready=%b want 0/1",
                         d, access_grant[d], cmd_ready[d]);
    end
  endtask

  task automatic do_write(input int d, input logic [PW_W-1:0] npw);
    int p;
    p = wr_pulses[d];
    pw_valid[d] = 1'b1; pw_data[d] = npw;
    tick();
    clear_inputs();
    checks++;
    if (mem_wr_en[d] !== 1'b1 || mem_rd_en[d] !== 1'b0 || mem_addr[d] !== cur_user[d] ||
        mem_wr_data[d] !== npw || cmd_ready[d] !== 1'b1) begin
      errors++; $display("FAIL write d=%0d wr=%b rd=%b addr=%0d data=%h ready=%b want 1/0/%0d/%h/1",
                         d, mem_wr_en[d], mem_rd_en[d], mem_addr[d], mem_wr_data[d],
                         cmd_ready[d], cur_user[d], npw);
    end
    tick();
    checks++;
    if (mem_wr_en[d] !== 1'b0 || wr_pulses[d] !== p + 1) begin
      errors++; $display("FAIL write_pulse d=%0d wr=%b pulses=%0d want 0/%0d",
                         d, mem_wr_en[d], wr_pulses[d], p + 1);
    end
    model_ram[d][cur_user[d]] = npw;
  endtask

  // Lockout phase; inputs are noise that must be ignored.
  task automatic do_lock(input int d);
`ifdef ACCESS_CTRL_LOCKOUT_TIMER_EN
    for (int i = 1; i < LOCK_CYCLES; i++) begin
      cmd_valid[d] = 1'($urandom_range(0, 1)); pw_valid[d] = 1'($urandom_range(0, 1));
      logout[d] = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (locked[d] !== 1'b1 || fail_count[d] !== 4'(MAX_FAILS) || access_grant[d] !== 1'b0) begin
        errors++; $display("FAIL lock_hold d=%0d cyc=%0d locked=%b fail=%0d want 1/%0d",
                           d, i, locked[d], fail_count[d], MAX_FAILS);
      end
    end
    clear_inputs();
    tick();
    checks++;
    if (locked[d] !== 1'b0 || cmd_ready[d] !== 1'b1 || fail_count[d] !== 4'd0) begin
      errors++; $display("FAIL lock_exit d=%0d locked=%b ready=%b fail=%0d want 0/1/0",
                         d, locked[d], cmd_ready[d], fail_count[d]);
    end
    model_fails[d] = 0;
`else
    for (int i = 1; i <= 100; i++) begin
      cmd_valid[d] = 1'($urandom_range(0, 1)); pw_valid[d] = 1'($urandom_range(0, 1));
      logout[d] = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (locked[d] !== 1'b1 || cmd_ready[d] !== 1'b0 || fail_count[d] !== 4'(MAX_FAILS)) begin
        errors++; $display("FAIL lock_hold d=%0d cyc=%0d locked=%b ready=%b fail=%0d want 1/0/%0d",
                           d, i, locked[d], cmd_ready[d], fail_count[d], MAX_FAILS);
      end
    end
    do_reset();
    checks++;
    if (locked[d] !== 1'b0 || cmd_ready[d] !== 1'b1) begin
      errors++; $display("FAIL lock_reset d=%0d locked=%b ready=%b want 0/1",
                         d, locked[d], cmd_ready[d]);
    end
`endif
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (outs(d) !== {1'b1, 28'd0}) begin
        errors++; $display("FAIL reset d=%0d outs=%h want %h", d, outs(d), {1'b1, 28'd0});
      end
    end
  endtask

  task automatic test_grant(input int d);
    int oc;
    set_ram(1'(d), 4'd5, 16'hBEEF);
    start(d, 4'd5, 1'b0);
    do_pw(d, 16'hBEEF, oc);
    for (int i = 0; i < 3; i++) begin
      pw_valid[d] = 1'b1; pw_data[d] = PW_W'($urandom);
      tick();
      checks++;
      if (access_grant[d] !== 1'b1 || mem_rd_en[d] !== 1'b0) begin
        errors++; $display("FAIL grant_hold d=%0d grant=%b rd=%b want 1/0",
                           d, access_grant[d], mem_rd_en[d]);
      end
    end
    clear_inputs();
    do_logout(d);
  endtask

  task automatic test_retry(input int d);
    int oc;
    set_ram(1'(d), 4'd2, 16'h1234);
    start(d, 4'd2, 1'b0);
    do_pw(d, 16'h1111, oc);
    do_pw(d, 16'h1234, oc);
    do_logout(d);
  endtask

  task automatic test_lockout(input int d);
    int oc;
    logic [PW_W-1:0] good;
    good = PW_W'($urandom);
    set_ram(1'(d), 4'd7, good);
    start(d, 4'd7, 1'b0);
    for (int i = 1; i <= MAX_FAILS; i++) do_pw(d, good ^ PW_W'(i), oc);
    do_lock(d);
  endtask

  task automatic test_change(input int d);
    int oc;
    set_ram(1'(d), 4'd3, 16'hAAAA);
    start(d, 4'd3, 1'b1);
    do_pw(d, 16'hAAAA, oc);
    do_write(d, 16'h5555);
    start(d, 4'd3, 1'b0);
    do_pw(d, 16'h5555, oc);
    do_logout(d);
  endtask

  task automatic test_reset_midop(input int d);
    int p;
    p = wr_pulses[d];
    set_ram(1'(d), 4'd9, 16'hC0DE);
    start(d, 4'd9, 1'b0);
    pw_valid[d] = 1'b1; pw_data[d] = 16'hC0DE;
    tick();
    pw_valid[d] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_fails[d] = 0;
    checks++;
    if (outs(d) !== {1'b1, 28'd0}) begin
      errors++; $display("FAIL midop_reset d=%0d outs=%h want %h", d, outs(d), {1'b1, 28'd0});
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (access_grant[d] !== 1'b0 || cmd_ready[d] !== 1'b1 || wr_pulses[d] !== p) begin
        errors++; $display("FAIL midop_after d=%0d grant=%b ready=%b pulses=%0d want 0/1/%0d",
                           d, access_grant[d], cmd_ready[d], wr_pulses[d], p);
      end
    end
  endtask

  task automatic test_random(input int d);
    int oc;
    logic [USER_W-1:0] u;
    logic [PW_W-1:0] pw;
    for (int s = 0; s < 12; s++) begin
      u = USER_W'($urandom);
      start(d, u, 1'($urandom_range(0, 3) == 0));
      for (int a = 0; a < MAX_FAILS; a++) begin
        if ($urandom_range(0, 2) == 0) pw = model_ram[d][u];
        else begin
          pw = PW_W'($urandom);
          if (pw == model_ram[d][u]) pw = pw ^ 16'h8000;
        end
        do_pw(d, pw, oc);
        if (oc == O_GRANT) begin do_logout(d); break; end
        if (oc == O_NEWPW) begin do_write(d, PW_W'($urandom)); break; end
        if (oc == O_LOCK)  begin do_lock(d); break; end
      end
    end
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (ram[d][a] !== model_ram[d][a]) begin
        errors++; $display("FAIL ram_content d=%0d addr=%0d got %h want %h",
                           d, a, ram[d][a], model_ram[d][a]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 16; a++) set_ram(1'(d), 4'(a), PW_W'($urandom));
    for (int d = 0; d < 2; d++) begin
      test_grant(d);
      test_retry(d);
      test_lockout(d);
      test_change(d);
      test_reset_midop(d);
      test_random(d);
    end
    checks++;
    if (overlap !== 0) begin
      errors++; $display("FAIL rd_wr_overlap got %0d want 0", overlap);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
